alarm_register_module: RTL and testbench

- Downstream stage of the set-time block: consumes its 16-bit STO bundle and stores one alarm per weekday in seven 13-bit registers.
- The seven registers feed back to the set-time block's Q_r0..Q_r6 inputs, so it can display or edit each alarm.
- Compares the current time against the alarm for the current day once per minute.
- Drives the buzzer through a RING/SNOOZE state machine with ring timeout and a snooze limit.

---
 rtl/alarm_register_module.sv | 217 +++++++++++++++++++++
 tb/tb_alarm_register_module.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_register_module.sv
`default_nettype none
// ============================================================================
// Module      : alarm_register_module
// Description : Per-weekday alarm store and buzzer controller. Sits downstream
//               of the set-time block: captures its 16-bit STI bundle into one
//               of seven 13-bit alarm registers (one per weekday) and feeds the
//               registers back as Q_r0..Q_r6 for display/editing. Once per
//               minute (MIN_TICK) the current time is compared against the
//               alarm stored for the current day. A match starts an alarm
//               event handled by an IDLE/RING/SNOOZE state machine with a ring
//               timeout and a per-event snooze limit.
//
// Ports       : Clk        - system clock, rising-edge active
//               CLEAR      - synchronous active-high reset
//               STI[15:0]  - set-time bundle {on, day[2:0], hh[4:0], m10[2:0], m1[3:0]}
//               LD_ALARM   - store STI into the register chosen by STI[14:12]
//               CTI[14:0]  - current time {day[2:0], hh/mm[11:0]}
//               MIN_TICK   - one-cycle pulse on the first cycle of a new minute
//               STOP       - level, ends ringing or snoozing
//               SNOOZE     - level, snooze request while ringing
//               Q_r0..Q_r6 - stored alarms {enable, hh/mm[11:0]}
//               ALARM      - buzzer drive
//               SNOOZED    - high while snoozing
//               ACTIVE_DAY - day index of the current/last alarm event
//
// Revision    : 1.0 - initial release
// ============================================================================
module alarm_register_module #(
    parameter int RING_MIN   = 5,   // minutes of ringing before auto-stop (1..15)
    parameter int SNOOZE_MIN = 9,   // minutes of snooze before re-ringing (1..15)
    parameter int MAX_SNOOZE = 3    // snoozes allowed per alarm event (0..15)
) (
    input  logic        Clk,
    input  logic        CLEAR,
    input  logic [15:0] STI,
    input  logic        LD_ALARM,
    input  logic [14:0] CTI,
    input  logic        MIN_TICK,
    input  logic        STOP,
    input  logic        SNOOZE,
    output logic [12:0] Q_r0,
    output logic [12:0] Q_r1,
    output logic [12:0] Q_r2,
    output logic [12:0] Q_r3,
    output logic [12:0] Q_r4,
    output logic [12:0] Q_r5,
    output logic [12:0] Q_r6,
    output logic        ALARM,
    output logic        SNOOZED,
    output logic [2:0]  ACTIVE_DAY
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // Timeouts are detected on the count *before* the increment, so the last
    // minute of a phase corresponds to a count of N-1.
    localparam logic [3:0] c_ring_last   = 4'(RING_MIN - 1);
    localparam logic [3:0] c_snooze_last = 4'(SNOOZE_MIN - 1);
    localparam logic [3:0] c_max_snooze  = 4'(MAX_SNOOZE);
    localparam logic [2:0] c_no_day      = 3'd7;

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_ring   = 2'd1;
    localparam logic [1:0] c_st_snooze = 2'd2;

    // ------------------------------------------------------------------------
    // Alarm register file
    // ------------------------------------------------------------------------
    logic [12:0] r_alarm [0:6];
    logic [2:0]  w_wr_day;

    assign w_wr_day = STI[14:12];

    // Day code 7 has no register behind it, so such a load is dropped.
    always_ff @(posedge Clk) begin
        if (CLEAR) begin
            for (int i = 0; i < 7; i++) begin
                r_alarm[i] <= '0;
            end
        end else if (LD_ALARM && (w_wr_day != c_no_day)) begin
            r_alarm[w_wr_day] <= {STI[15], STI[11:0]};
        end
    end

    assign Q_r0 = r_alarm[0];
    assign Q_r1 = r_alarm[1];
    assign Q_r2 = r_alarm[2];
    assign Q_r3 = r_alarm[3];
    assign Q_r4 = r_alarm[4];
    assign Q_r5 = r_alarm[5];
    assign Q_r6 = r_alarm[6];

    // ------------------------------------------------------------------------
    // Minute compare
    // ------------------------------------------------------------------------
    // The selected register reads the pre-write value, so a load landing in
    // the same cycle as the tick compares against the old alarm. Day 7 selects
    // nothing and yields an all-zero (disabled) entry, which never matches.
    logic [2:0]  w_cur_day;
    logic [12:0] w_sel_alarm;
    logic        w_match;

    assign w_cur_day = CTI[14:12];

    always_comb begin
        w_sel_alarm = '0;
        for (int i = 0; i < 7; i++) begin
            if (w_cur_day == 3'(i)) begin
                w_sel_alarm = r_alarm[i];
            end
        end
    end

    assign w_match = MIN_TICK && w_sel_alarm[12] && (w_sel_alarm[11:0] == CTI[11:0]);

    // ------------------------------------------------------------------------
    // Ring / snooze state machine
    // ------------------------------------------------------------------------
    logic [1:0] r_state;
    logic [3:0] r_ring_cnt;
    logic [3:0] r_snz_cnt;
    logic [3:0] r_snooze_used;
    logic [2:0] r_active_day;
    logic       r_alarm_out;
    logic       r_snoozed;

    logic [1:0] w_state_nxt;
    logic [3:0] w_ring_cnt_nxt;
    logic [3:0] w_snz_cnt_nxt;
    logic [3:0] w_snooze_used_nxt;
    logic [2:0] w_active_day_nxt;

    always_comb begin
        w_state_nxt       = r_state;
        w_ring_cnt_nxt    = r_ring_cnt;
        w_snz_cnt_nxt     = r_snz_cnt;
        w_snooze_used_nxt = r_snooze_used;
        w_active_day_nxt  = r_active_day;

        case (r_state)
            c_st_idle: begin
                // Only an IDLE match starts an event; it latches the day so a
                // later edit or disable of that register cannot disturb it.
                if (w_match) begin
                    w_state_nxt       = c_st_ring;
                    w_ring_cnt_nxt    = '0;
                    w_snooze_used_nxt = '0;
                    w_active_day_nxt  = w_cur_day;
                end
            end

            c_st_ring: begin
                // STOP beats SNOOZE beats the minute timeout. An accepted
                // snooze consumes this cycle's tick; a refused one (limit
                // reached) lets the tick count as a ringing minute.
                if (STOP) begin
                    w_state_nxt = c_st_idle;
                end else if (SNOOZE && (r_snooze_used < c_max_snooze)) begin
                    w_state_nxt       = c_st_snooze;
                    w_snz_cnt_nxt     = '0;
                    w_snooze_used_nxt = r_snooze_used + 4'd1;
                end else if (MIN_TICK) begin
                    w_ring_cnt_nxt = r_ring_cnt + 4'd1;
                    if (r_ring_cnt == c_ring_last) begin
                        w_state_nxt = c_st_idle;
                    end
                end
            end

            c_st_snooze: begin
                // SNOOZE is deliberately not looked at here.
                if (STOP) begin
                    w_state_nxt = c_st_idle;
                end else if (MIN_TICK) begin
                    w_snz_cnt_nxt = r_snz_cnt + 4'd1;
                    if (r_snz_cnt == c_snooze_last) begin
                        w_state_nxt    = c_st_ring;
                        w_ring_cnt_nxt = '0;
                    end
                end
            end

            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // Outputs are flopped from the next-state decode so they change on the
    // same edge as the state register and carry no combinational glitches.
    always_ff @(posedge Clk) begin
        if (CLEAR) begin
            r_state       <= c_st_idle;
            r_ring_cnt    <= '0;
            r_snz_cnt     <= '0;
            r_snooze_used <= '0;
            r_active_day  <= '0;
            r_alarm_out   <= 1'b0;
            r_snoozed     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_ring_cnt    <= w_ring_cnt_nxt;
            r_snz_cnt     <= w_snz_cnt_nxt;
            r_snooze_used <= w_snooze_used_nxt;
            r_active_day  <= w_active_day_nxt;
            r_alarm_out   <= (w_state_nxt == c_st_ring);
            r_snoozed     <= (w_state_nxt == c_st_snooze);
        end
    end

    assign ALARM      = r_alarm_out;
    assign SNOOZED    = r_snoozed;
    assign ACTIVE_DAY = r_active_day;

endmodule
`default_nettype wire

// File: tb/tb_alarm_register_module.sv
`default_nettype none
// ============================================================================
// Module      : tb_alarm_register_module
// Description : Self-checking bench for alarm_register_module. Directed
//               scenarios followed by randomized traffic, every cycle compared
//               against an event-level reference model of the alarm clock.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alarm_register_module;

    localparam int RING_MIN   = 5;
    localparam int SNOOZE_MIN = 9;
    localparam int MAX_SNOOZE = 3;

    logic        Clk;
    logic        CLEAR;
    logic [15:0] STI;
    logic        LD_ALARM;
    logic [14:0] CTI;
    logic        MIN_TICK;
    logic        STOP;
    logic        SNOOZE;
    logic [12:0] q_r [7];
    logic        ALARM;
    logic        SNOOZED;
    logic [2:0]  ACTIVE_DAY;

    alarm_register_module #(
        .RING_MIN   (RING_MIN),
        .SNOOZE_MIN (SNOOZE_MIN),
        .MAX_SNOOZE (MAX_SNOOZE)
    ) u_dut (
        .Clk        (Clk),
        .CLEAR      (CLEAR),
        .STI        (STI),
        .LD_ALARM   (LD_ALARM),
        .CTI        (CTI),
        .MIN_TICK   (MIN_TICK),
        .STOP       (STOP),
        .SNOOZE     (SNOOZE),
        .Q_r0       (q_r[0]),
        .Q_r1       (q_r[1]),
        .Q_r2       (q_r[2]),
        .Q_r3       (q_r[3]),
        .Q_r4       (q_r[4]),
        .Q_r5       (q_r[5]),
        .Q_r6       (q_r[6]),
        .ALARM      (ALARM),
        .SNOOZED    (SNOOZED),
        .ACTIVE_DAY (ACTIVE_DAY)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: an alarm "event" that is either absent, ringing or
    // sleeping, tracked in elapsed minutes rather than hardware counters.
    // ------------------------------------------------------------------------
    typedef enum int {M_QUIET, M_RINGING, M_SLEEPING} mode_t;

    mode_t       m_mode;
    int          m_minutes_rung;
    int          m_minutes_slept;
    int          m_snoozes_taken;
    logic [2:0]  m_day;
    logic [12:0] m_alarm [7];

    task automatic model_step(input bit clr, input bit ld, input logic [15:0] sti,
                              input logic [14:0] cti, input bit tick,
                              input bit stop, input bit snz);
        bit hit;
        int d;
        if (clr) begin
            m_mode = M_QUIET;
            m_minutes_rung = 0;
            m_minutes_slept = 0;
            m_snoozes_taken = 0;
            m_day = 3'd0;
            foreach (m_alarm[i]) m_alarm[i] = 13'h0;
            return;
        end
        d = int'(cti[14:12]);
        hit = tick && (d < 7) && m_alarm[d][12] && (m_alarm[d][11:0] == cti[11:0]);
        case (m_mode)
            M_QUIET: if (hit) begin
                m_mode = M_RINGING;
                m_minutes_rung = 0;
                m_snoozes_taken = 0;
                m_day = cti[14:12];
            end
            M_RINGING: begin
                if (stop) m_mode = M_QUIET;
                else if (snz && m_snoozes_taken < MAX_SNOOZE) begin
                    m_mode = M_SLEEPING;
                    m_minutes_slept = 0;
                    m_snoozes_taken++;
                end else if (tick) begin
                    m_minutes_rung++;
                    if (m_minutes_rung >= RING_MIN) m_mode = M_QUIET;
                end
            end
            M_SLEEPING: begin
                if (stop) m_mode = M_QUIET;
                else if (tick) begin
                    m_minutes_slept++;
                    if (m_minutes_slept >= SNOOZE_MIN) begin
                        m_mode = M_RINGING;
                        m_minutes_rung = 0;
                    end
                end
            end
            default: m_mode = M_QUIET;
        endcase
        if (ld && sti[14:12] != 3'd7) m_alarm[sti[14:12]] = {sti[15], sti[11:0]};
    endtask

    task automatic compare_all();
        check_eq("ALARM", 32'(ALARM), 32'(m_mode == M_RINGING));
        check_eq("SNOOZED", 32'(SNOOZED), 32'(m_mode == M_SLEEPING));
        check_eq("ACTIVE_DAY", 32'(ACTIVE_DAY), 32'(m_day));
        for (int i = 0; i < 7; i++) begin
            check_eq($sformatf("Q_r%0d", i), 32'(q_r[i]), 32'(m_alarm[i]));
        end
    endtask

    // One clock: drive inputs, step the model at the edge, check 1 ns later.
    task automatic cyc(input bit clr, input bit ld, input logic [15:0] sti,
                       input logic [14:0] cti, input bit tick,
                       input bit stop, input bit snz);
        CLEAR = clr; LD_ALARM = ld; STI = sti; CTI = cti;
        MIN_TICK = tick; STOP = stop; SNOOZE = snz;
        @(posedge Clk);
        model_step(clr, ld, sti, cti, tick, stop, snz);
        #1;
        compare_all();
    endtask

    // Tick with a time that cannot match anything loaded in the directed part.
    task automatic blank_ticks(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 16'h0, 15'h7FFF, 1, 0, 0);
    endtask

    initial begin
        CLEAR = 1'b1; LD_ALARM = 1'b0; STI = '0; CTI = '0;
        MIN_TICK = 1'b0; STOP = 1'b0; SNOOZE = 1'b0;
        @(negedge Clk);

        // Reset state
        cyc(1, 0, 16'h0, 15'h0, 0, 0, 0);
        check_eq("rst_alarm", 32'(ALARM), 32'd0);
        check_eq("rst_q2", 32'(q_r[2]), 32'd0);

        // 1. Alarm fires
        cyc(0, 1, 16'hA3B0, 15'h0, 0, 0, 0);
        check_eq("load_q2", 32'(q_r[2]), 32'h13B0);
        cyc(0, 0, 16'h0, 15'h23B0, 1, 0, 0);
        check_eq("fire_alarm", 32'(ALARM), 32'd1);
        check_eq("fire_day", 32'(ACTIVE_DAY), 32'd2);

        // 3. Ring timeout after RING_MIN ticks
        blank_ticks(RING_MIN - 1);
        check_eq("timeout_pre", 32'(ALARM), 32'd1);
        blank_ticks(1);
        check_eq("timeout_post", 32'(ALARM), 32'd0);
        check_eq("hold_day", 32'(ACTIVE_DAY), 32'd2);

        // 2. Non-match: wrong day, then disabled register
        cyc(0, 0, 16'h0, 15'h33B0, 1, 0, 0);
        check_eq("wrong_day", 32'(ALARM), 32'd0);
        cyc(0, 1, 16'h23B0, 15'h0, 0, 0, 0);
        cyc(0, 0, 16'h0, 15'h23B0, 1, 0, 0);
        check_eq("disabled", 32'(ALARM), 32'd0);
        cyc(0, 1, 16'hA3B0, 15'h0, 0, 0, 0);

        // 4. Snooze / re-ring, limit, stop
        cyc(0, 0, 16'h0, 15'h23B0, 1, 0, 0);
        for (int s = 0; s < MAX_SNOOZE; s++) begin
            cyc(0, 0, 16'h0, 15'h0, 0, 0, 1);
            check_eq("snz_enter", 32'(SNOOZED), 32'd1);
            check_eq("snz_quiet", 32'(ALARM), 32'd0);
            blank_ticks(SNOOZE_MIN - 1);
            check_eq("snz_hold", 32'(SNOOZED), 32'd1);
            blank_ticks(1);
            check_eq("rering", 32'(ALARM), 32'd1);
        end
        cyc(0, 0, 16'h0, 15'h0, 0, 0, 1);
        check_eq("snz_limit", 32'(ALARM), 32'd1);
        cyc(0, 0, 16'h0, 15'h0, 0, 1, 0);
        check_eq("stop_alarm", 32'(ALARM), 32'd0);
        check_eq("stop_snz", 32'(SNOOZED), 32'd0);

        // 5. Simultaneous events
        cyc(0, 0, 16'h0, 15'h23B0, 1, 0, 0);
        cyc(0, 0, 16'h0, 15'h0, 0, 1, 1);
        check_eq("stop_and_snz", 32'(ALARM | SNOOZED), 32'd0);
        cyc(0, 1, 16'hA3B1, 15'h23B0, 1, 0, 0);
        check_eq("old_value_match", 32'(ALARM), 32'd1);
        check_eq("new_value_q2", 32'(q_r[2]), 32'h13B1);
        cyc(0, 0, 16'h0, 15'h0, 0, 1, 0);
        cyc(0, 1, 16'hF3B0, 15'h0, 0, 0, 0);
        check_eq("day7_nowrite", 32'(q_r[2]), 32'h13B1);

        // 6. Reset during snooze with every register loaded
        for (int d = 0; d < 7; d++) cyc(0, 1, {1'b1, 3'(d), 12'h3B0}, 15'h0, 0, 0, 0);
        cyc(0, 0, 16'h0, 15'h53B0, 1, 0, 0);
        cyc(0, 0, 16'h0, 15'h0, 0, 0, 1);
        check_eq("pre_clr_snz", 32'(SNOOZED), 32'd1);
        cyc(1, 1, 16'hA3B0, 15'h0, 1, 1, 1);
        check_eq("clr_alarm", 32'(ALARM | SNOOZED), 32'd0);
        check_eq("clr_day", 32'(ACTIVE_DAY), 32'd0);
        check_eq("clr_q5", 32'(q_r[5]), 32'd0);

        // Randomized traffic, biased toward hitting stored alarms
        for (int n = 0; n < 3000; n++) begin
            bit          clr, ld, tick, stop, snz;
            logic [15:0] sti;
            logic [14:0] cti;
            int          d;
            clr  = ($urandom_range(0, 299) == 0);
            ld   = ($urandom_range(0, 7) == 0);
            sti  = 16'($urandom);
            sti[15] = ($urandom_range(0, 3) != 0);
            tick = ($urandom_range(0, 2) == 0);
            stop = ($urandom_range(0, 24) == 0);
            snz  = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 1) == 1) begin
                d   = int'($urandom_range(0, 6));
                cti = {3'(d), m_alarm[d][11:0]};
            end else begin
                cti = 15'($urandom);
            end
            cyc(clr, ld, sti, cti, tick, stop, snz);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
